// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool; half-width line buffer holds one row of pair maxima.
// Optional fused ReLU on the output: define MAXPOOL_RELU_EN.
module maxpool_2x2_stream #(
  parameter int IMG_SIZE = 32,
  parameter int CH       = 64,
  parameter int BW       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vld_in,
  input  logic [CH-1:0][BW-1:0]  in,
  output logic                   vld_out,
  output logic [CH-1:0][BW-1:0]  out
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int AW   = (HALF > 2) ? $clog2(HALF) : 1;

  typedef logic [CH-1:0][BW-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  pix_t          hold_q, hold_d;
  pix_t          out_q, out_d;
  logic          vld_out_q, vld_out_d;

  pix_t          linebuf_q [HALF];
  logic [AW-1:0] lb_addr;
  logic          lb_wr_en;
  pix_t          lb_rd, pair_max, pool_max, pool_act;
  logic          col_last, row_last;

  function automatic pix_t pix_max(input pix_t a, input pix_t b);
    pix_t m;
    for (int ch = 0; ch < CH; ch++) begin
      m[ch] = ($signed(a[ch]) > $signed(b[ch])) ? a[ch] : b[ch];
    end
    return m;
  endfunction

  always_comb begin
    col_last = (col_q == CW'(IMG_SIZE - 1));
    row_last = (row_q == CW'(IMG_SIZE - 1));
    lb_addr  = AW'(col_q >> 1);
    lb_rd    = linebuf_q[lb_addr];
    pair_max = pix_max(hold_q, in);
    pool_max = pix_max(lb_rd, pair_max);
    pool_act = pool_max;
`ifdef MAXPOOL_RELU_EN
    for (int ch = 0; ch < CH; ch++) begin
      if (pool_max[ch][BW-1]) pool_act[ch] = '0;
    end
`endif
  end

  // Even column latches the left pixel; odd column either parks the pair max
  // (even row) or combines it with the parked value from the row above.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    hold_d    = hold_q;
    out_d     = out_q;
    vld_out_d = 1'b0;
    lb_wr_en  = 1'b0;
    if (vld_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = in;
      end else if (!row_q[0]) begin
        lb_wr_en = 1'b1;
      end else begin
        out_d     = pool_act;
        vld_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      hold_q    <= '0;
      out_q     <= '0;
      vld_out_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      vld_out_q <= vld_out_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clock) begin
    if (lb_wr_en) linebuf_q[lb_addr] <= pair_max;
  end

  assign vld_out = vld_out_q;
  assign out     = out_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream (IMG_SIZE=4, CH=2); MAXPOOL_RELU_EN switches the model too.
module tb_maxpool_2x2_stream;

  localparam int IMG = 4;
  localparam int CH  = 2;
  localparam int BW  = 16;
  localparam int W   = CH * BW;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  vld_in = 1'b0;
  logic [CH-1:0][BW-1:0] din = '0;
  logic [CH-1:0][BW-1:0] dout;
  logic                  vld_out;

  always #5 clock = ~clock;

  maxpool_2x2_stream #(.IMG_SIZE(IMG), .CH(CH), .BW(BW)) dut (
    .clock   (clock),
    .reset   (reset),
    .vld_in  (vld_in),
    .in      (din),
    .vld_out (vld_out),
    .out     (dout)
  );

  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pix [IMG][IMG];
  int         trig_cnt = 0;
  int         trig_seen = 0;
  int         pulse_cnt = 0;
  logic       trig_d1 = 1'b0;
  logic       rst_prev = 1'b0;
  logic       mon_en = 1'b0;
  logic [W-1:0] last_out = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] smax(input logic [BW-1:0] a, input logic [BW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [W-1:0] model_pool(input int r, input int c);
    logic [W-1:0]  res;
    logic [BW-1:0] m;
    for (int ch = 0; ch < CH; ch++) begin
      m = smax(pix[r-1][c-1][ch*BW +: BW], pix[r-1][c][ch*BW +: BW]);
      m = smax(m, pix[r][c-1][ch*BW +: BW]);
      m = smax(m, pix[r][c][ch*BW +: BW]);
`ifdef MAXPOOL_RELU_EN
      if ($signed(m) < 0) m = '0;
`endif
      res[ch*BW +: BW] = m;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] ramp(input int r, input int c, input int off);
    logic [BW-1:0] a, b;
    a = BW'(4 * r + c + off);
    b = BW'(off - (4 * r + c));
    return {b, a};
  endfunction

  task automatic send_pixel(input int r, input int c, input logic [W-1:0] v, input int gap);
    @(posedge clock); #1;
    vld_in = 1'b1;
    din    = v;
    pix[r][c] = v;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_q.push_back(model_pool(r, c));
      trig_cnt++;
    end
    repeat (gap) begin
      @(posedge clock); #1;
      vld_in = 1'b0;
    end
  endtask

  task automatic send_image(input int mode, input int off, input int gap, input int npix);
    logic [W-1:0] v;
    for (int i = 0; i < npix; i++) begin
      if (mode == 0) v = ramp(i / IMG, i % IMG, off);
      else if (i / IMG == 2 && i % IMG == 3) v = {2{16'h7FFF}};
      else v = {2{16'h8000}};
      send_pixel(i / IMG, i % IMG, v, gap);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      vld_in = 1'b0;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clock); #1;
    reset  = 1'b1;
    vld_in = 1'b1;
    din    = W'($urandom);
    repeat (n - 1) begin
      @(posedge clock); #1;
      din = W'($urandom);
    end
    @(posedge clock); #1;
    reset  = 1'b0;
    vld_in = 1'b0;
  endtask

  // Output becomes visible one negedge after the driver's trigger cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (rst_prev) begin
        check("rst_vld", W'(vld_out), W'(0));
        check("rst_out", dout, '0);
        last_out = '0;
      end else begin
        check("vld_out", W'(vld_out), W'(trig_d1));
        if (trig_d1) begin
          if (vld_out) check("out", dout, exp_q.pop_front());
          else void'(exp_q.pop_front());
        end else if (!vld_out) begin
          check("out_hold", dout, last_out);
        end
        if (vld_out) begin
          pulse_cnt++;
          last_out = dout;
        end
      end
      trig_d1   = reset ? 1'b0 : (trig_cnt != trig_seen);
      trig_seen = trig_cnt;
      if (reset) exp_q.delete();
      rst_prev  = reset;
    end
  end

  initial begin
    @(posedge clock); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle(2);

    send_image(0, 0, 0, IMG * IMG);
    idle(4);
    send_image(0, 0, 3, IMG * IMG);
    idle(4);
    send_image(1, 0, 0, IMG * IMG);
    idle(4);
    send_image(0, 0, 0, IMG * IMG);
    send_image(0, 100, 0, IMG * IMG);
    idle(4);
    send_image(0, 0, 0, IMG + 1);
    pulse_reset(2);
    send_image(0, 0, $urandom_range(0, 2), IMG * IMG);
    idle(4);

    check("q_empty", W'(exp_q.size()), W'(0));
    check("pulses", W'(pulse_cnt), W'(24));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_stream.md
Name: maxpool_2x2_stream

Overview:
- Streaming 2x2, stride-2 signed max-pool stage that sits directly downstream of the serial conv windower.
- Consumes the conv's parallel 16-bit per-channel outputs, one pixel per vld_in pulse, in raster order.
- Emits one pooled pixel per 2x2 block.
- Uses a half-width line buffer so only one image row of pair-maxima is stored.

Parameters:
- IMG_SIZE, 32, input image width and height in pixels; must be even and >= 2.
- CH, 64, number of channels per pixel.
- BW, 16, bits per channel word, two's-complement signed.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- vld_in  input  1  input pixel valid; may be sparse (e.g. 1 in 4 cycles); any gap length allowed.
- in  input  [CH-1:0][BW-1:0]  input pixel, all channels.
- vld_out  output  1  pooled pixel valid, single-cycle pulse.
- out  output  [CH-1:0][BW-1:0]  pooled pixel, per-channel signed max.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - vld_out=0, out=0.
  - col_cntr=0, row_cntr=0, hold register=0.
  - Line buffer contents are don't-care, because every entry is written before it is read.
- Counters:
  - col_cntr 0..IMG_SIZE-1 and row_cntr 0..IMG_SIZE-1 advance only on vld_in.
  - col wraps to 0 and increments row at col=IMG_SIZE-1.
  - row wraps to 0 after the last pixel of the image.
  - The next image starts with no dead cycles; a back-to-back image in the following cycle is accepted.
- Datapath, on vld_in, per channel, signed compares:
  - col even: hold <= in.
  - col odd: pm = max(hold, in).
    - row even: linebuf[col>>1] <= pm.
    - row odd: out <= max(linebuf[col>>1], pm), vld_out <= 1.
- Line buffer:
  - IMG_SIZE/2 entries x CH*BW bits.
  - Read and write addresses are col>>1.
  - A write on an even row and a read on an odd row never target the same entry in the same cycle.
- Latency: vld_out rises the cycle after the vld_in that carries pixel (2r+1, 2c+1).
- vld_out is 0 in all other cycles.
- out holds its last value when vld_out=0.
- Max rule:
  - Strict signed comparison.
  - On ties the values are equal, so which operand is selected does not matter.
  - No saturation or width growth; output width equals input width.
- Output count: exactly (IMG_SIZE/2)^2 vld_out pulses per image.
- Reset mid-image:
  - Counters return to 0 and partial pooling state is discarded.
  - The next vld_in is treated as pixel (0,0).
  - Any vld_out scheduled for the cycle after reset is suppressed.
- vld_in asserted during reset: ignored.
- No backpressure. The downstream stage must accept every vld_out pulse.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- When defined:
  - Each output channel is clamped as out_ch = (max < 0) ? 0 : max, registered in the same cycle.
  - This is a fused ReLU; latency is unchanged.
- When undefined: raw signed max is output, and negative values pass through.

Test Plan:
- IMG_SIZE=4, CH=2, vld_in every cycle; pixel (r,c) ch0 = 4r+c, ch1 = -(4r+c) -> 4 pulses.
  - ch0 = 5, 7, 13, 15.
  - ch1 = 0, -2, -8, -10.
  - Each pulse arrives one cycle after pixel (1,1), (1,3), (3,1), (3,3) respectively.
- Same image with vld_in asserted 1 cycle in 4 -> identical values; each pulse lands exactly one cycle after its triggering vld_in; no extra pulses.
- All pixels 0x8000, except 0x7FFF at pixel (2,3) -> outputs 0x8000, 0x8000, 0x8000, 0x7FFF; confirms the signed compare.
- Two images back-to-back with no gap, second image = first +100 -> 8 pulses; the second set equals the first set +100; no line-buffer cross-contamination.
- Assert reset after pixel (1,0) of the first image, then send a full fresh image -> no pulse during or right after reset; then exactly 4 correct pulses.
- With MAXPOOL_RELU_EN defined, ch1 of the first test -> 0, 0, 0, 0; ch0 unchanged at 5, 7, 13, 15.
